comma_search_seq: RTL and testbench
===================================

Name: comma_search_seq

Overview:
- Clocked, parametrised successor to the combinational comma detector.
- Accepts one word per start handshake and scans it serially, one bit position per clock, for a parametrised comma pattern.
- Reports the lowest matching position and tracks a lock state when the same alignment repeats across consecutive words.
- Sits in the receive path ahead of the word aligner and supplies the alignment index.

Parameters:
- WORD_W, 32, width of the searched word; must be ≥ COMMA_W.
- COMMA_W, 4, comma pattern width.
- COMMA, 4'b1101, comma pattern; must be nonzero (elaboration check).
- LOCK_CNT, 3, consecutive identical finds required for lock; must be ≥ 1.
- IDX_W (localparam), $clog2(WORD_W), index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- word_in  in  WORD_W  word to search; sampled on the accepting edge only.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle result pulse.
- found  out  1  comma found in the last completed search.
- index_out  out  IDX_W  bit position of the comma LSB within word_in; 0 when not found.
- locked  out  1  alignment lock.

Behaviour:
- Reset (async, any state, including mid-scan):
  - FSM goes to IDLE.
  - busy, done, found, index_out, locked all 0.
  - Lock counter and last index cleared.
  - The in-flight search is discarded.
- FSM states IDLE, SCAN, DONE.
  - IDLE→SCAN on start=1: latch word_in into shift register sreg; set pos=0.
  - SCAN, each cycle, checks these in order:
    - (a) sreg[COMMA_W-1:0]==COMMA → match at pos.
    - (b) sreg==0 → early no-match.
    - (c) pos==WORD_W-COMMA_W → no-match, all positions exhausted.
    - Otherwise sreg>>=1, pos+=1, zero filled at MSB.
  - SCAN→DONE on any of (a)–(c).
  - DONE→IDLE unconditionally after one cycle.
- Outputs (all registered):
  - done=1 exactly during the DONE cycle.
  - found and index_out update at the SCAN→DONE edge and hold until the next result or reset.
- Latency, counted in edges from the accepting edge to the edge that raises done:
  - match at position p: p+1.
  - early zero at pos p: p+1.
  - exhaustive no-match: WORD_W-COMMA_W+1.
  - Lowest position always wins.
- start while busy is ignored, not queued. Earliest next accept is the first IDLE cycle after done.
- word_in changes after acceptance have no effect.
- Lock tracking, updated on the DONE-entry edge:
  - found and index==last_idx: cnt = min(cnt+1, LOCK_CNT).
  - found and index!=last_idx: cnt=1, last_idx=index.
  - not found: cnt=0.
  - locked = (cnt==LOCK_CNT), registered, so it changes in the same cycle as done.

Optional Feature:
- Macro COMMA_SEARCH_INV_EN.
- When defined:
  - ~COMMA is also matched; ~COMMA must be nonzero.
  - Adds output port polarity (1 bit, reset 0): 1 = inverted comma matched. It holds like found.
  - If both patterns match at the same position, the true comma wins (polarity=0).
  - Lock tracking also requires polarity equal to the previous find; a polarity change restarts cnt=1.
- When undefined:
  - Only COMMA is matched and the polarity port does not exist.
  - Timing is otherwise identical.

Decomposition:
- Package comma_search_pkg holds:
  - the state encoding constants S_IDLE, S_SCAN, S_DONE;
  - the index-width helper function;
  - default COMMA/COMMA_W constants.
- Sub-module comma_lock_tracker holds last_idx, cnt and locked.
  - Inputs: clk, rst, res_valid (the DONE-entry strobe), found, index, and polarity when the macro is defined.
  - Output: locked.

Test Plan:
- Reset then start with word_in=32'h0000_000D → done at edge 1 after accept, found=1, index_out=0.
- word_in=32'h0000_00D0 → done at edge 5, found=1, index_out=4; start pulsed during SCAN is ignored (no second done).
- word_in=32'h0000_0000 → done at edge 1, found=0, index_out=0; word_in=32'hFFFF_FFF0 → done at edge 29, found=0.
- Lock, LOCK_CNT=3:
  - Search 32'h0000_00D0 three times back-to-back → locked=1 with the third done.
  - Then 32'h0000_000D → locked=0, found=1, index_out=0.
  - Then a no-match word → cnt 0, locked stays 0.
- Assert rst for 1 cycle at edge 3 of a scan of 32'h00D0_0000 → all outputs 0 immediately, no done; the next start on the same word gives index_out=20 at edge 21.
- word_in=32'h0000_0020:
  - with COMMA_SEARCH_INV_EN → done at edge 5, found=1, index_out=4, polarity=1;
  - without the macro → done at edge 7 (early zero), found=0.

Source files
------------

// File: rtl/comma_search_pkg.sv
// Shared types and constants for the serial comma search block.
package comma_search_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam int             DEF_COMMA_W = 4;
    localparam logic [3:0]     DEF_COMMA   = 4'b1101;

    // Index width that stays legal for degenerate (width 1) ranges.
    function automatic int idx_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/comma_search_seq_if.sv
// Request/result bundle between a word source and comma_search_seq.
// The polarity signal exists only when COMMA_SEARCH_INV_EN is defined.
interface comma_search_seq_if
    import comma_search_pkg::*;
#(
    parameter int WORD_W = 32
);
    localparam int IDX_W = idx_w(WORD_W);

    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              busy;
    logic              done;
    logic              found;
    logic [IDX_W-1:0]  index_out;
    logic              locked;
`ifdef COMMA_SEARCH_INV_EN
    logic              polarity;
`endif

    modport master (
        output start, word_in,
        input  busy, done, found, index_out, locked
`ifdef COMMA_SEARCH_INV_EN
        , input polarity
`endif
    );

    modport slave (
        input  start, word_in,
        output busy, done, found, index_out, locked
`ifdef COMMA_SEARCH_INV_EN
        , output polarity
`endif
    );
endinterface

// File: rtl/comma_search_seq_lock.sv
// Alignment lock tracker: counts consecutive identical finds up to LOCK_CNT.
// With COMMA_SEARCH_INV_EN, the polarity must also repeat.
module comma_lock_tracker
    import comma_search_pkg::*;
#(
    parameter int IDX_W    = 5,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic             found,
    input  logic [IDX_W-1:0] index,
`ifdef COMMA_SEARCH_INV_EN
    input  logic             polarity,
`endif
    output logic             locked
);
    localparam int CNT_W = idx_w(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] last_idx, last_idx_nx;
    logic             same;
`ifdef COMMA_SEARCH_INV_EN
    logic             last_pol, last_pol_nx;
    assign same = (index == last_idx) && (polarity == last_pol);
`else
    assign same = (index == last_idx);
`endif

    always_comb begin
        cnt_nx      = cnt;
        last_idx_nx = last_idx;
`ifdef COMMA_SEARCH_INV_EN
        last_pol_nx = last_pol;
`endif
        if (res_valid) begin
            if (!found) begin
                cnt_nx = '0;
            end else if (same) begin
                cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end else begin
                cnt_nx      = CNT_W'(1);
                last_idx_nx = index;
`ifdef COMMA_SEARCH_INV_EN
                last_pol_nx = polarity;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            last_idx <= '0;
            locked   <= 1'b0;
`ifdef COMMA_SEARCH_INV_EN
            last_pol <= 1'b0;
`endif
        end else begin
            cnt      <= cnt_nx;
            last_idx <= last_idx_nx;
            // Registered off the next count so lock moves with done.
            locked   <= (cnt_nx == CNT_MAX);
`ifdef COMMA_SEARCH_INV_EN
            last_pol <= last_pol_nx;
`endif
        end
    end
endmodule

// File: rtl/comma_search_seq.sv
// Serial comma search: one bit position per clock, lowest match wins.
// Optional inverted-comma matching via COMMA_SEARCH_INV_EN.
module comma_search_seq
    import comma_search_pkg::*;
#(
    parameter int                 WORD_W   = 32,
    parameter int                 COMMA_W  = DEF_COMMA_W,
    parameter logic [COMMA_W-1:0] COMMA    = DEF_COMMA,
    parameter int                 LOCK_CNT = 3
) (
    input logic               clk,
    input logic               rst,
    comma_search_seq_if.slave bus
);
    localparam int IDX_W = idx_w(WORD_W);
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WORD_W - COMMA_W);

    if (WORD_W < COMMA_W) begin : g_chk_w
        $error("WORD_W must be >= COMMA_W");
    end
    if (COMMA == '0) begin : g_chk_comma
        $error("COMMA must be nonzero");
    end
    if (LOCK_CNT < 1) begin : g_chk_lock
        $error("LOCK_CNT must be >= 1");
    end
`ifdef COMMA_SEARCH_INV_EN
    if (~COMMA == '0) begin : g_chk_inv
        $error("~COMMA must be nonzero");
    end
`endif

    state_t            state, state_nx;
    logic [WORD_W-1:0] sreg, sreg_nx;
    logic [IDX_W-1:0]  pos, pos_nx;
    logic              res_valid, res_found, hit_t, hit;
    logic [IDX_W-1:0]  res_idx;
    logic              found_q;
    logic [IDX_W-1:0]  idx_q;

    assign hit_t = (sreg[COMMA_W-1:0] == COMMA);
`ifdef COMMA_SEARCH_INV_EN
    logic res_pol, pol_q;
    assign hit = hit_t || (sreg[COMMA_W-1:0] == ~COMMA);
`else
    assign hit = hit_t;
`endif

    always_comb begin
        state_nx  = state;
        sreg_nx   = sreg;
        pos_nx    = pos;
        res_valid = 1'b0;
        res_found = 1'b0;
        res_idx   = '0;
`ifdef COMMA_SEARCH_INV_EN
        res_pol   = 1'b0;
`endif
        case (state)
            S_IDLE: if (bus.start) begin
                state_nx = S_SCAN;
                sreg_nx  = bus.word_in;
                pos_nx   = '0;
            end
            S_SCAN: begin
                if (hit) begin
                    state_nx  = S_DONE;
                    res_valid = 1'b1;
                    res_found = 1'b1;
                    res_idx   = pos;
`ifdef COMMA_SEARCH_INV_EN
                    // True comma takes priority at the same position.
                    res_pol   = !hit_t;
`endif
                end else if (sreg == '0 || pos == LAST_POS) begin
                    state_nx  = S_DONE;
                    res_valid = 1'b1;
                end else begin
                    sreg_nx = sreg >> 1;
                    pos_nx  = pos + 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sreg    <= '0;
            pos     <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
`ifdef COMMA_SEARCH_INV_EN
            pol_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            pos   <= pos_nx;
            if (res_valid) begin
                found_q <= res_found;
                idx_q   <= res_idx;
`ifdef COMMA_SEARCH_INV_EN
                pol_q   <= res_pol;
`endif
            end
        end
    end

    comma_lock_tracker #(.IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT)) u_lock (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .found     (res_found),
        .index     (res_idx),
`ifdef COMMA_SEARCH_INV_EN
        .polarity  (res_pol),
`endif
        .locked    (bus.locked)
    );

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.found     = found_q;
    assign bus.index_out = idx_q;
`ifdef COMMA_SEARCH_INV_EN
    assign bus.polarity  = pol_q;
`endif
endmodule

// File: tb/tb_comma_search_seq.sv
// Scoreboard bench for comma_search_seq: directed plan plus random words,
// checked against a position-by-position reference of the search rules.
module tb_comma_search_seq;
    localparam int         WORD_W   = 32;
    localparam int         COMMA_W  = 4;
    localparam logic [3:0] COMMA    = 4'b1101;
    localparam int         LOCK_CNT = 3;

    typedef struct {
        logic       found;
        logic [4:0] idx;
        logic       pol;
        logic       locked;
        int         acc_edge;
    } exp_t;

    typedef struct {
        logic       found;
        logic [4:0] idx;
        logic       pol;
    } hist_t;

    logic clk = 0;
    logic rst = 1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_done = 0;
    exp_t  sb[$];
    hist_t hist[$];

    comma_search_seq_if #(.WORD_W(WORD_W)) bus ();

    comma_search_seq #(
        .WORD_W(WORD_W), .COMMA_W(COMMA_W), .COMMA(COMMA), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: walk every legal position of the original word in order.
    function automatic exp_t model(logic [31:0] w);
        exp_t e;
        logic [31:0] sh;
        logic [3:0]  win;
        hist_t h;
        int lat;
        e.found = 0; e.idx = 0; e.pol = 0;
        lat = WORD_W - COMMA_W + 1;
        for (int p = 0; p <= WORD_W - COMMA_W; p++) begin
            sh  = w >> p;
            win = sh[3:0];
            if (win == COMMA) begin
                e.found = 1; e.idx = 5'(p); lat = p + 1; break;
`ifdef COMMA_SEARCH_INV_EN
            end else if (win == ~COMMA) begin
                e.found = 1; e.idx = 5'(p); e.pol = 1; lat = p + 1; break;
`endif
            end else if (sh == 0) begin
                lat = p + 1; break;
            end
        end
        h.found = e.found; h.idx = e.idx; h.pol = e.pol;
        hist.push_back(h);
        e.locked = (hist.size() >= LOCK_CNT);
        for (int i = 0; i < LOCK_CNT && e.locked; i++) begin
            h = hist[hist.size() - 1 - i];
            if (!h.found || h.idx != e.idx || h.pol != e.pol) e.locked = 0;
        end
        e.acc_edge = lat;  // latency for now; caller converts to absolute edge
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(logic [31:0] w);
        exp_t e;
        wait_idle();
        bus.start   = 1;
        bus.word_in = w;
        e = model(w);
        e.acc_edge = cyc + 1 + e.acc_edge;  // edge at which done should rise
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start   = 0;
        bus.word_in = $urandom;
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            chk("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_edge", cyc, e.acc_edge);
                chk("found", int'(bus.found), int'(e.found));
                chk("index_out", int'(bus.index_out), int'(e.idx));
                chk("locked", int'(bus.locked), int'(e.locked));
`ifdef COMMA_SEARCH_INV_EN
                chk("polarity", int'(bus.polarity), int'(e.pol));
`endif
            end
        end
        prev_done <= bus.done;
    end

    task automatic check_zero(string tag);
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_done"},  int'(bus.done), 0);
        chk({tag, "_found"}, int'(bus.found), 0);
        chk({tag, "_index"}, int'(bus.index_out), 0);
        chk({tag, "_lock"},  int'(bus.locked), 0);
`ifdef COMMA_SEARCH_INV_EN
        chk({tag, "_pol"},   int'(bus.polarity), 0);
`endif
    endtask

    initial begin
        logic [31:0] w, prev;
        int n;
        bus.start   = 0;
        bus.word_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;

        issue(32'h0000_000D);
        // Start during SCAN must be ignored; a second done would be spurious.
        issue(32'h0000_00D0);
        @(negedge clk);
        bus.start = 1; bus.word_in = 32'h0000_000D;
        @(negedge clk);
        bus.start = 0;
        issue(32'h0000_0000);
        issue(32'hFFFF_FFF0);
        repeat (3) issue(32'h0000_00D0);
        issue(32'h0000_000D);
        issue(32'hFFFF_FFF0);
        issue(32'h0000_0020);

        // Asynchronous reset on the third edge of a scan discards it.
        issue(32'h00D0_0000);
        repeat (2) @(posedge clk);
        rst = 1;
        sb.delete();
        hist.delete();
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1 rst = 0;
        issue(32'h00D0_0000);

        prev = 32'h0000_00D0;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: w = $urandom;
                1: begin
                    n = $urandom_range(0, 28);
                    w = (32'(COMMA) << n) | ($urandom << (n + 4));
                end
                2: w = prev;
                default: w = $urandom >> $urandom_range(0, 31);
            endcase
            issue(w);
            prev = w;
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
